// File: rtl/regwrite_arbiter_pkg.sv
// Shared widths, zero-register address, FSM state encoding and write payload
// for the register-file write-port arbiter.
package regwrite_arbiter_pkg;

  localparam int unsigned REGADDR_W = 5;
  localparam int unsigned REG_W     = 32;

  // Writes to register 0 are architecturally discarded.
  localparam logic [REGADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REGADDR_W-1:0] waddr;
    logic [REG_W-1:0]     wdata;
  } reg_wr_t;

endpackage

// File: rtl/regwrite_arbiter_wq.sv
// wq_fifo: pending long-latency write queue.
// Ports: clk/rst; push_i with push_addr_i/push_data_i; pop_i; full_o, empty_o,
// count_o; head_addr_o/head_data_o (oldest entry); ent_addr_o/ent_valid_o give a
// per-slot view used for decode hazard lookup.
module wq_fifo
  import regwrite_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push_i,
  input  logic [REGADDR_W-1:0]              push_addr_i,
  input  logic [REG_W-1:0]                  push_data_i,
  input  logic                              pop_i,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [$clog2(DEPTH):0]            count_o,
  output logic [REGADDR_W-1:0]              head_addr_o,
  output logic [REG_W-1:0]                  head_data_o,
  output logic [DEPTH-1:0][REGADDR_W-1:0]   ent_addr_o,
  output logic [DEPTH-1:0]                  ent_valid_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  reg_wr_t           mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  valid_q, valid_d;

  // Payload storage needs no reset; slot validity is tracked separately.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= '{waddr: push_addr_i, wdata: push_data_i};
  end

  // Slot validity: pop and push never target the same slot in one cycle.
  always_comb begin
    valid_d = valid_q;
    if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
    if (push_i) valid_d[wr_ptr_q] = 1'b1;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
      if (pop_i)  rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
      count_q <= CNT_W'(count_q + CNT_W'(push_i) - CNT_W'(pop_i));
      valid_q <= valid_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) ent_addr_o[i] = mem_q[i].waddr;
  end

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_addr_o = mem_q[rd_ptr_q].waddr;
  assign head_data_o = mem_q[rd_ptr_q].wdata;
  assign ent_valid_o = valid_q;

endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back has priority; results
// from the long-latency unit are queued and written when the port is free. If the
// queue head is blocked for STARVE_LIMIT cycles, stall_req freezes the pipeline
// until the queue has drained.
// Ports: clk, rst (async, active-high); wb_* write-back request; lu_* long-latency
// result handshake; rf_* regfile write port; stall_req; q_addr/q_hit hazard lookup.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_we,
  input  logic [REGADDR_W-1:0] wb_waddr,
  input  logic [REG_W-1:0]     wb_wdata,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [REGADDR_W-1:0] lu_waddr,
  input  logic [REG_W-1:0]     lu_wdata,
  output logic                 rf_we,
  output logic [REGADDR_W-1:0] rf_waddr,
  output logic [REG_W-1:0]     rf_wdata,
  output logic                 stall_req,
  input  logic [REGADDR_W-1:0] q_addr,
  output logic                 q_hit
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  logic                         q_full, q_empty;
  logic [CNT_W-1:0]             q_count;
  logic [REGADDR_W-1:0]         head_addr;
  logic [REG_W-1:0]             head_data;
  logic [DEPTH-1:0][REGADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0]             ent_valid;

  logic wb_use_c, push_c, pop_c, last_c;

  arb_state_e        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              stall_q;

  wq_fifo #(.DEPTH(DEPTH)) u_wq (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_addr_i (lu_waddr),
    .push_data_i (lu_wdata),
    .pop_i       (pop_c),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count),
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .ent_addr_o  (ent_addr),
    .ent_valid_o (ent_valid)
  );

  // Port arbitration: a write-back to r0 leaves the port to the queue head.
  always_comb begin
    wb_use_c = wb_we && (wb_waddr != ZERO_REG);
    pop_c    = !rst && !wb_use_c && !q_empty;
    push_c   = !rst && lu_valid && !q_full && (lu_waddr != ZERO_REG);
    last_c   = pop_c && !push_c && (q_count == CNT_W'(1));
    rf_we    = 1'b0;
    rf_waddr = ZERO_REG;
    rf_wdata = '0;
    if (!rst) begin
      if (wb_use_c) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (!q_empty) begin
        rf_we    = 1'b1;
        rf_waddr = head_addr;
        rf_wdata = head_data;
      end
    end
  end

  assign lu_ready  = !q_full;
  assign stall_req = stall_q;

  // Hazard lookup sees current slots, so an entry popped this cycle still hits.
  always_comb begin
    q_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == q_addr)) q_hit = 1'b1;
    end
    if (q_addr == ZERO_REG) q_hit = 1'b0;
  end

  // Starvation FSM with registered stall request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wait_q <= '0;
          if (push_c) state_q <= ST_PEND;
        end
        ST_PEND: begin
          if (pop_c) begin
            wait_q <= '0;
            if (last_c) state_q <= ST_IDLE;
          end else if (wait_q == WAIT_W'(STARVE_LIMIT - 1)) begin
            state_q <= ST_FORCE;
            stall_q <= 1'b1;
            wait_q  <= '0;
          end else begin
            wait_q <= WAIT_W'(wait_q + 1'b1);
          end
        end
        ST_FORCE: begin
          wait_q <= '0;
          if (last_c) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wait_q  <= '0;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_regwrite_arbiter;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned STARVE = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_waddr = '0;
  logic [31:0] lu_wdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [4:0]  q_addr = '0;
  logic        q_hit;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [4:0]  m_addr[$];
  logic [31:0] m_data[$];
  bit          m_stall;
  int          m_blocked;

  regwrite_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .q_addr(q_addr), .q_hit(q_hit)
  );

  always #5 clk = ~clk;

  // Pipeline contract: no write-back while the pipeline is asked to freeze.
  always @(posedge clk) begin
    if (!rst) assert (!(stall_req && wb_we)) else $error("contract: wb_we asserted while stall_req high");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic [4:0] qa);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld; q_addr = qa;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    m_addr.delete(); m_data.delete(); m_stall = 0; m_blocked = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h55, 5'd4);
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_lu_ready: got %b want 1", lu_ready); end
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL reset_q_hit: got %b want 0", q_hit); end
    vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall_req: got %b want 0", stall_req); end
    apply_reset();
  endtask

  task automatic test_single_push();
    apply_reset();
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0); #1;
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", lu_ready); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL single_no_write_yet: got %b want 0", rf_we); end
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5); #1;
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      miscompares++; $display("FAIL single_write: got we=%b a=%0d d=%h want we=1 a=5 d=deadbeef", rf_we, rf_waddr, rf_wdata); end
    vectors++; if (q_hit !== 1'b1) begin miscompares++; $display("FAIL single_hit_on_pop: got %b want 1", q_hit); end
    @(negedge clk); #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL single_empty_after: got %b want 0", rf_we); end
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL single_hit_after: got %b want 0", q_hit); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    @(negedge clk); set_in(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'h200, 5'd0);
    @(negedge clk); set_in(1'b1, 5'd1, 32'hA2, 1'b1, 5'd3, 32'h300, 5'd0); #1;
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_one: got %b want 1", lu_ready); end
    @(negedge clk); set_in(1'b1, 5'd1, 32'hA3, 1'b1, 5'd4, 32'h400, 5'd0); #1;
    vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b want 0", lu_ready); end
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'hA3}) begin
      miscompares++; $display("FAIL b2b_wb_priority: got we=%b a=%0d d=%h want we=1 a=1 d=a3", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h400, 5'd0); #1;
    vectors++; if (lu_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_pop_cycle: got %b want 0", lu_ready); end
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h200}) begin
      miscompares++; $display("FAIL b2b_pop1: got a=%0d d=%h want a=2 d=200", rf_waddr, rf_wdata); end
    @(negedge clk); #1;
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_pop: got %b want 1", lu_ready); end
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h300}) begin
      miscompares++; $display("FAIL b2b_pop2: got a=%0d d=%h want a=3 d=300", rf_waddr, rf_wdata); end
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0); #1;
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h400}) begin
      miscompares++; $display("FAIL b2b_pop3: got a=%0d d=%h want a=4 d=400", rf_waddr, rf_wdata); end
    @(negedge clk); #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL b2b_drained: got %b want 0", rf_we); end
  endtask

  task automatic test_starve();
    apply_reset();
    @(negedge clk); set_in(1'b1, 5'd1, 32'd0, 1'b1, 5'd9, 32'h900, 5'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); set_in(1'b1, 5'd1, 32'(k), (k == 1), 5'd10, 32'hA00, 5'd0); #1;
      vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL starve_early_c%0d: got %b want 0", k, stall_req); end
    end
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0); #1;
    vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("FAIL starve_c9_stall: got %b want 1", stall_req); end
    vectors++; if ({rf_we, rf_waddr} !== {1'b1, 5'd9}) begin miscompares++; $display("FAIL starve_drain1: got we=%b a=%0d want 1/9", rf_we, rf_waddr); end
    @(negedge clk); #1;
    vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("FAIL starve_c10_stall: got %b want 1", stall_req); end
    vectors++; if ({rf_we, rf_waddr} !== {1'b1, 5'd10}) begin miscompares++; $display("FAIL starve_drain2: got we=%b a=%0d want 1/10", rf_we, rf_waddr); end
    @(negedge clk); #1;
    vectors++; if ({stall_req, rf_we} !== 2'b00) begin miscompares++; $display("FAIL starve_release: got stall=%b we=%b want 0/0", stall_req, rf_we); end
  endtask

  task automatic test_zero_addr();
    apply_reset();
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD, 5'd0); #1;
    vectors++; if (lu_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready: got %b want 1", lu_ready); end
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0); #1;
    vectors++; if ({rf_we, q_hit} !== 2'b00) begin miscompares++; $display("FAIL zero_not_queued: got we=%b hit=%b want 0/0", rf_we, q_hit); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); set_in(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'd0, 5'd0);
    end
    #1;
    vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL zero_stays_idle: got stall=%b want 0", stall_req); end
    @(negedge clk); set_in(1'b1, 5'd0, 32'hFF, 1'b1, 5'd6, 32'h600, 5'd6); #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL zero_wb_r0_unused: got %b want 0", rf_we); end
    @(negedge clk); set_in(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 5'd6); #1;
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h600}) begin
      miscompares++; $display("FAIL zero_wb_r0_port_free: got we=%b a=%0d d=%h want 1/6/600", rf_we, rf_waddr, rf_wdata); end
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
  endtask

  task automatic test_qhit();
    apply_reset();
    @(negedge clk); set_in(1'b1, 5'd1, 32'd0, 1'b1, 5'd7, 32'h700, 5'd7); #1;
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL qhit_before_push: got %b want 0", q_hit); end
    @(negedge clk); set_in(1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7); #1;
    vectors++; if (q_hit !== 1'b1) begin miscompares++; $display("FAIL qhit_match: got %b want 1", q_hit); end
    q_addr = 5'd0; #1;
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL qhit_r0: got %b want 0", q_hit); end
    q_addr = 5'd8; #1;
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL qhit_other: got %b want 0", q_hit); end
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7); #1;
    vectors++; if ({q_hit, rf_waddr} !== {1'b1, 5'd7}) begin miscompares++; $display("FAIL qhit_pop_cycle: got hit=%b a=%0d want 1/7", q_hit, rf_waddr); end
    @(negedge clk); #1;
    vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("FAIL qhit_after_drain: got %b want 0", q_hit); end
  endtask

  task automatic test_reset_mid_force();
    apply_reset();
    @(negedge clk); set_in(1'b1, 5'd1, 32'd0, 1'b1, 5'd11, 32'hB00, 5'd0);
    @(negedge clk); set_in(1'b1, 5'd1, 32'd0, 1'b1, 5'd12, 32'hC00, 5'd0);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk); set_in(1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    end
    @(negedge clk); set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11); #1;
    vectors++; if ({stall_req, lu_ready} !== 2'b10) begin miscompares++; $display("FAIL rstforce_pre: got stall=%b ready=%b want 1/0", stall_req, lu_ready); end
    rst = 1'b1; #1;
    vectors++; if ({stall_req, lu_ready, rf_we, q_hit} !== 4'b0100) begin
      miscompares++; $display("FAIL rstforce_in_reset: got stall=%b ready=%b we=%b hit=%b want 0/1/0/0", stall_req, lu_ready, rf_we, q_hit); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      vectors++; if ({rf_we, stall_req} !== 2'b00) begin miscompares++; $display("FAIL rstforce_after_c%0d: got we=%b stall=%b want 0/0", k, rf_we, stall_req); end
    end
  endtask

  task automatic test_random();
    logic        we, lv, exp_ready, exp_we, exp_hit, wb_wins, popped, was_busy;
    logic [4:0]  wa, la, qa, exp_a;
    logic [31:0] wd, ld, exp_d;
    int          busy;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      busy = ((cyc / 60) % 2 == 0) ? 9 : 4;
      @(negedge clk);
      we = m_stall ? 1'b0 : ($urandom_range(0, 9) < busy);
      wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) wa = 5'd0;
      wd = $urandom;
      lv = 1'($urandom_range(0, 1));
      la = 5'($urandom_range(0, 7));
      ld = $urandom;
      qa = 5'($urandom_range(0, 7));
      set_in(we, wa, wd, lv, la, ld, qa);
      #1;
      exp_ready = (m_addr.size() < DEPTH);
      wb_wins   = we && (wa != 5'd0);
      exp_we    = wb_wins || (m_addr.size() > 0);
      exp_a     = wb_wins ? wa : ((m_addr.size() > 0) ? m_addr[0] : 5'd0);
      exp_d     = wb_wins ? wd : ((m_data.size() > 0) ? m_data[0] : 32'd0);
      exp_hit   = 1'b0;
      foreach (m_addr[i]) if (qa != 5'd0 && m_addr[i] == qa) exp_hit = 1'b1;
      vectors++; if (lu_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, lu_ready, exp_ready); end
      vectors++; if (rf_we !== exp_we) begin miscompares++; $display("FAIL rnd_rf_we c%0d: got %b want %b", cyc, rf_we, exp_we); end
      if (exp_we) begin
        vectors++; if ({rf_waddr, rf_wdata} !== {exp_a, exp_d}) begin
          miscompares++; $display("FAIL rnd_rf_data c%0d: got a=%0d d=%h want a=%0d d=%h", cyc, rf_waddr, rf_wdata, exp_a, exp_d); end
      end
      vectors++; if (q_hit !== exp_hit) begin miscompares++; $display("FAIL rnd_q_hit c%0d: got %b want %b", cyc, q_hit, exp_hit); end
      vectors++; if (stall_req !== m_stall) begin miscompares++; $display("FAIL rnd_stall c%0d: got %b want %b", cyc, stall_req, m_stall); end
      // Advance the model by one clock.
      was_busy = (m_addr.size() > 0);
      popped   = !wb_wins && was_busy;
      if (popped) begin void'(m_addr.pop_front()); void'(m_data.pop_front()); end
      if (lv && exp_ready && la != 5'd0) begin m_addr.push_back(la); m_data.push_back(ld); end
      if (m_stall) begin
        m_blocked = 0;
        if (m_addr.size() == 0) m_stall = 0;
      end else if (was_busy) begin
        if (popped) m_blocked = 0;
        else begin
          m_blocked++;
          if (m_blocked >= STARVE) begin m_stall = 1; m_blocked = 0; end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_starve();
    test_zero_addr();
    test_qhit();
    test_reset_mid_force();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the pending-write queue depth (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 8, SHALL set the consecutive blocked-cycle count that forces a drain.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  SHALL be asynchronous, active-high reset.
REQ-005 wb_we  in  1  pipeline write-back write enable.
REQ-006 wb_waddr  in  REGADDRBUS  pipeline write-back destination.
REQ-007 wb_wdata  in  REGBUS  pipeline write-back data.
REQ-008 lu_valid  in  1  long-latency unit result valid.
REQ-009 lu_ready  out  1  arbiter can accept a long-latency result.
REQ-010 lu_waddr  in  REGADDRBUS  long-latency result destination.
REQ-011 lu_wdata  in  REGBUS  long-latency result data.
REQ-012 rf_we, rf_waddr, rf_wdata  out  1/REGADDRBUS/REGBUS  regfile write port drive.
REQ-013 stall_req  out  1  registered request to freeze the pipeline and bubble WB.
REQ-014 q_addr  in  REGADDRBUS  hazard query address from decode.
REQ-015 q_hit  out  1  a queued write targets q_addr.

Function
REQ-016 Transfer on lu_valid && lu_ready; lu_ready SHALL equal !full (combinational from current count only).
REQ-017 Transfers with lu_waddr==0 SHALL be accepted and discarded, never queued.
REQ-018 Same-cycle push and pop SHALL be legal at any occupancy, including one entry below full.
REQ-019 rf port, combinational: wb_we && wb_waddr!=0 -> drive wb fields; else queue non-empty -> drive head, pop it; else rf_we=0.
REQ-020 wb_we with wb_waddr==0 SHALL not use the port, leaving it free for the queue head.
REQ-021 FSM states: IDLE (queue empty), PEND (non-empty, counting), FORCE (stall_req=1).
REQ-022 IDLE->PEND on push; PEND->IDLE when the queue becomes empty.
REQ-023 In PEND a wait counter SHALL increment each cycle the head is not popped and clear on every pop.
REQ-024 PEND->FORCE on the cycle the counter reaches STARVE_LIMIT-1 while blocked; stall_req SHALL rise the next cycle.
REQ-025 In FORCE the queue SHALL drain one entry per cycle; FORCE->IDLE when empty, stall_req low the following cycle.
REQ-026 Pipeline contract: wb_we==0 whenever stall_req==1; a violation SHALL still give wb priority and SHALL be flagged by bench assertion.
REQ-027 q_hit SHALL be combinational: 1 iff a valid entry has waddr==q_addr and q_addr!=0; an entry popped this cycle still counts.
REQ-028 Entries SHALL pop in FIFO order; pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 rst SHALL clear queue, pointers, counter; state=IDLE; stall_req=0; rf_we=0; lu_ready=1; q_hit=0.
REQ-030 Reset mid-operation SHALL discard queued writes with no rf write in the reset cycle.

Structure
REQ-031 REGADDRBUS, REGBUS, zero-register address and FSM state encodings SHALL live in the shared macro header.
REQ-032 The queue SHALL be one sub-module, wq_fifo (push/pop/full/empty/head plus per-entry addr/valid view).

Verification
REQ-033 Idle lu_valid, waddr=5, data=0xDEADBEEF, wb_we=0 -> same push; rf_we=1 with addr 5 next cycle; queue empty.
REQ-034 Two pushes back-to-back, wb busy -> lu_ready=0 after second; third lu_valid held off until a pop.
REQ-035 Queue non-empty, wb_we=1 every cycle for 8 cycles -> stall_req=1 on cycle 9; drains; stall_req=0 after empty.
REQ-036 lu push with waddr=0 -> accepted, no rf write, q_hit stays 0, state stays IDLE.
REQ-037 Queue holds addr 7; q_addr=7 -> q_hit=1; q_addr=0 -> q_hit=0; after drain q_addr=7 -> q_hit=0.
REQ-038 rst pulse with 2 queued entries, mid-FORCE -> stall_req=0, lu_ready=1, no subsequent rf write.
